// File: rtl/capture_ctrl.sv
`timescale 1ns/1ps
// capture_ctrl
// Sequences sample capture into the logic analyzer's channel RAM queue.
// It generates the RAM write enable and a circular write address. It waits
// until enough pre-trigger history is in the RAM, accepts a trigger, and then
// counts trig_pos post-trigger samples. When the capture is complete it pulses
// set_capture_done. At that point waddr points at the oldest sample, which is
// where the dump starts.
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   wrt_smpl         one-cycle strobe: a decimated sample is valid this cycle
//   run              capture enable (run bit from trigger config)
//   capture_done     capture_done status bit held in the config block
//   triggered        trigger event from the trigger logic
//   trig_pos         number of samples to capture after the trigger
//   we               RAM write enable, shared by all channels
//   waddr            RAM write address; after done, address of oldest sample
//   armed            pre-trigger history satisfied, trigger may fire
//   set_capture_done one-cycle pulse that sets capture_done in the config block
module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wrt_smpl,
  input  logic            run,
  input  logic            capture_done,
  input  logic            triggered,
  input  logic [LOG2-1:0] trig_pos,
  output logic            we,
  output logic [LOG2-1:0] waddr,
  output logic            armed,
  output logic            set_capture_done
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);
  localparam logic [LOG2:0]   FULL_CNT  = (LOG2 + 1)'(ENTRIES);

  state_t          state, next_state;
  // smpl_cnt needs one extra bit so that it can hold ENTRIES itself.
  logic [LOG2:0]   smpl_cnt;
  logic [LOG2-1:0] trig_cnt;
  logic            trig_lat;

  logic [LOG2-1:0] trig_eff;
  logic [LOG2:0]   hist_sum;
  logic            start;
  logic            clr_cnt;

  // The post-trigger count cannot exceed the RAM depth. Otherwise the oldest
  // pre-trigger sample would be overwritten before the dump.
  always_comb begin
    trig_eff = (trig_pos > LAST_ADDR) ? LAST_ADDR : trig_pos;
    hist_sum = smpl_cnt + {1'b0, trig_eff};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and output logic. A run=0 condition overrides everything else.
  // It forces IDLE, suppresses the write and the done pulse, and clears the
  // capture counters.
  always_comb begin
    next_state       = state;
    we               = 1'b0;
    armed            = 1'b0;
    set_capture_done = 1'b0;
    start            = 1'b0;
    clr_cnt          = 1'b0;
    case (state)
      IDLE: begin
        if (run && !capture_done) begin
          next_state = CAPTURE;
          start      = 1'b1;
        end
      end
      CAPTURE: begin
        armed = !trig_lat && (hist_sum >= FULL_CNT);
        // The done cycle issues no write. Because of that, the next write
        // position is also the oldest sample still held in the RAM.
        if (trig_lat && (trig_cnt == trig_eff)) begin
          set_capture_done = 1'b1;
          next_state       = DONE;
        end else begin
          we = wrt_smpl;
        end
      end
      DONE: begin
        if (!capture_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (!run) begin
      next_state       = IDLE;
      we               = 1'b0;
      set_capture_done = 1'b0;
      start            = 1'b0;
      clr_cnt          = 1'b1;
    end
  end

  // Write address, history counter, post-trigger counter and trigger latch.
  // A write in the same cycle as the trigger still counts as history, because
  // trig_lat only takes effect from the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr    <= '0;
      smpl_cnt <= '0;
      trig_cnt <= '0;
      trig_lat <= 1'b0;
    end else if (clr_cnt) begin
      smpl_cnt <= '0;
      trig_cnt <= '0;
      trig_lat <= 1'b0;
    end else if (start) begin
      waddr    <= '0;
      smpl_cnt <= '0;
      trig_cnt <= '0;
      trig_lat <= 1'b0;
    end else begin
      if (we) begin
        waddr <= (waddr == LAST_ADDR) ? '0 : waddr + 1'b1;
        if (smpl_cnt != FULL_CNT) smpl_cnt <= smpl_cnt + 1'b1;
        if (trig_lat) trig_cnt <= trig_cnt + 1'b1;
      end
      if (armed && triggered) trig_lat <= 1'b1;
    end
  end

endmodule
